ps2_key_receiver: RTL and testbench

PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

---
 rtl/ps2_key_receiver_pkg.sv | 34 +++
 rtl/ps2_key_receiver_sync_edge.sv | 32 +++
 rtl/ps2_key_receiver.sv | 174 +++++++++++++++++
 tb/tb_ps2_key_receiver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_receiver_pkg.sv
// Shared definitions for the PS/2 key receiver: FSM encoding, prefix bytes
// and the scan codes of the five game keys.
package ps2_key_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_FIRE  = 8'h29;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic fire;
  } keys_t;

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic oddParityOk(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_receiver_sync_edge.sv
// Two-flop synchronizers for the PS/2 lines plus a falling-edge detector on
// the synchronized keyboard clock.
module ps2_sync_edge (
  input  logic Clk,
  input  logic Reset_bar,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall_pulse
);

  logic [1:0] clkSync_q;
  logic [1:0] dataSync_q;
  logic       clkPrev_q;

  // Everything resets to the idle bus level so reset never fakes an edge.
  always_ff @(posedge Clk) begin
    if (!Reset_bar) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
      clkPrev_q  <= 1'b1;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2_clk};
      dataSync_q <= {dataSync_q[0], ps2_data};
      clkPrev_q  <= clkSync_q[1];
    end
  end

  assign data_s     = dataSync_q[1];
  assign fall_pulse = clkPrev_q & ~clkSync_q[1];

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard frame receiver with E0/F0 prefix tracking and held-state
// outputs for the arrow keys and space (fire).
module ps2_key_receiver
  import ps2_key_receiver_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TIMEOUT_CYC = 50_000
) (
  input  logic       Clk,
  input  logic       Reset_bar,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       key_up,
  output logic       key_down,
  output logic       key_left,
  output logic       key_right,
  output logic       key_fire,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYC - 1);

  // CLK_HZ only documents the clock rate that TIMEOUT_CYC was chosen for.
  logic unusedClkHz;
  assign unusedClkHz = (CLK_HZ > 0);

  logic dataS;
  logic fallPulse;

  ps2_sync_edge u_sync_edge (
    .Clk       (Clk),
    .Reset_bar (Reset_bar),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_s    (dataS),
    .fall_pulse(fallPulse)
  );

  ps2_state_e    state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bitCnt_q;
  logic [TW-1:0] timeout_q;
  logic          parityOk_q;
  logic          ext_q;
  logic          brk_q;
  logic [7:0]    scanCode_q;
  logic          codeValid_q;
  logic          frameErr_q;
  keys_t         keys_q;
  keys_t         keys_d;

  // Receive FSM: every bit is taken on a detected ps2_clk falling edge; a
  // stalled frame is abandoned once the inter-edge timeout expires.
  always_ff @(posedge Clk) begin
    if (!Reset_bar) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bitCnt_q    <= '0;
      timeout_q   <= '0;
      parityOk_q  <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      scanCode_q  <= '0;
      codeValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      codeValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      if (fallPulse) begin
        timeout_q <= '0;
        case (state_q)
          ST_IDLE: begin
            if (!dataS) begin
              state_q  <= ST_DATA;
              bitCnt_q <= '0;
            end else begin
              frameErr_q <= 1'b1;
              ext_q      <= 1'b0;
              brk_q      <= 1'b0;
            end
          end
          ST_DATA: begin
            shift_q  <= {dataS, shift_q[7:1]};
            bitCnt_q <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              state_q <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            parityOk_q <= oddParityOk(shift_q, dataS);
            state_q    <= ST_STOP;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            if (dataS && parityOk_q) begin
              scanCode_q  <= shift_q;
              codeValid_q <= 1'b1;
              if (shift_q == PREFIX_EXT) begin
                ext_q <= 1'b1;
              end else if (shift_q == PREFIX_BRK) begin
                brk_q <= 1'b1;
              end else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
              end
            end else begin
              frameErr_q <= 1'b1;
              ext_q      <= 1'b0;
              brk_q      <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE) begin
        if (timeout_q == TimeoutLast) begin
          state_q    <= ST_IDLE;
          frameErr_q <= 1'b1;
          timeout_q  <= '0;
          shift_q    <= '0;
          bitCnt_q   <= '0;
          ext_q      <= 1'b0;
          brk_q      <= 1'b0;
        end else begin
          timeout_q <= timeout_q + TW'(1);
        end
      end
    end
  end

  logic byteGood;
  logic decodeByte;

  assign byteGood   = fallPulse && (state_q == ST_STOP) && dataS && parityOk_q;
  assign decodeByte = byteGood && (shift_q != PREFIX_EXT) && (shift_q != PREFIX_BRK);

  // Arrows only match with the E0 prefix, fire only without it.
  always_comb begin
    keys_d = keys_q;
    if (decodeByte) begin
      if (ext_q) begin
        case (shift_q)
          CODE_UP:    keys_d.up    = ~brk_q;
          CODE_DOWN:  keys_d.down  = ~brk_q;
          CODE_LEFT:  keys_d.left  = ~brk_q;
          CODE_RIGHT: keys_d.right = ~brk_q;
          default:    keys_d       = keys_q;
        endcase
      end else if (shift_q == CODE_FIRE) begin
        keys_d.fire = ~brk_q;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_bar) begin
      keys_q <= '0;
    end else begin
      keys_q <= keys_d;
    end
  end

  assign scan_code  = scanCode_q;
  assign code_valid = codeValid_q;
  assign frame_err  = frameErr_q;
  assign key_up     = keys_q.up;
  assign key_down   = keys_q.down;
  assign key_left   = keys_q.left;
  assign key_right  = keys_q.right;
  assign key_fire   = keys_q.fire;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Scoreboard bench for ps2_key_receiver: stimulus pushes expected pulses,
// a monitor pops them whenever code_valid or frame_err fires.
module tb_ps2_key_receiver;
  import ps2_key_receiver_pkg::*;

  localparam int TIMEOUT = 200;
  localparam int HALF    = 6;

  logic       Clk       = 1'b0;
  logic       Reset_bar = 1'b0;
  logic       ps2_clk   = 1'b1;
  logic       ps2_data  = 1'b1;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;
  logic       key_up, key_down, key_left, key_right, key_fire;

  typedef struct {
    bit         isErr;
    logic [7:0] code;
  } exp_t;

  exp_t expQ[$];
  int   checkCount    = 0;
  int   failCount     = 0;
  int   cycleCount    = 0;
  int   lastFallCycle = 0;

  ps2_key_receiver #(
    .CLK_HZ     (50_000_000),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .Clk       (Clk),
    .Reset_bar (Reset_bar),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (scan_code),
    .code_valid(code_valid),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .key_fire  (key_fire),
    .frame_err (frame_err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkKeys(input string name, input logic [4:0] expected);
    checkOutput(name, {27'd0, key_up, key_down, key_left, key_right, key_fire}, {27'd0, expected});
  endtask

  // Frame bit 0 is the start bit, bit 10 the stop bit.
  function automatic logic [10:0] frameBits(input logic [7:0] code, input bit badParity);
    logic par;
    par = ~^code;
    if (badParity) par = ~par;
    return {1'b1, par, code, 1'b0};
  endfunction

  task automatic sendBit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge Clk);
    ps2_clk = 1'b0;
    lastFallCycle = cycleCount;
    repeat (HALF) @(negedge Clk);
    ps2_clk = 1'b1;
  endtask

  task automatic sendPartial(input logic [10:0] bits, input int first, input int last);
    for (int i = first; i <= last; i++) sendBit(bits[i]);
  endtask

  task automatic applyStimulus(input logic [7:0] code, input bit badParity = 1'b0);
    exp_t e;
    e.isErr = badParity;
    e.code  = code;
    expQ.push_back(e);
    sendPartial(frameBits(code, badParity), 0, 10);
    repeat (10) @(negedge Clk);
  endtask

  task automatic pushErrors(input int n);
    exp_t e;
    e.isErr = 1'b1;
    e.code  = 8'h00;
    for (int i = 0; i < n; i++) expQ.push_back(e);
  endtask

  always @(negedge Clk) begin : monitor
    exp_t e;
    if (code_valid === 1'b1 || frame_err === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected pulse {code_valid,frame_err}", {30'd0, code_valid, frame_err}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("pulse kind {code_valid,frame_err}", {30'd0, code_valid, frame_err},
                    e.isErr ? 32'd1 : 32'd2);
        if (!e.isErr) checkOutput("scan_code on code_valid", {24'd0, scan_code}, {24'd0, e.code});
      end
    end
  end

  initial begin : watchdog
    repeat (20000) @(posedge Clk);
    $display("[TB] FAIL watchdog: simulation did not complete, got %0d cycles, expected < 20000", cycleCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int latency;
    repeat (3) @(negedge Clk);
    checkOutput("reset scan_code", {24'd0, scan_code}, 32'h00);
    checkOutput("reset code_valid", {31'd0, code_valid}, 32'd0);
    checkOutput("reset frame_err", {31'd0, frame_err}, 32'd0);
    checkKeys("reset keys", 5'b00000);
    Reset_bar = 1'b1;
    repeat (5) @(negedge Clk);

    applyStimulus(8'h29);
    checkKeys("fire make", 5'b00001);
    applyStimulus(8'hF0);
    applyStimulus(8'h29);
    checkKeys("fire break", 5'b00000);

    applyStimulus(8'hE0);
    applyStimulus(8'h75);
    checkKeys("up make", 5'b10000);
    applyStimulus(8'hE0);
    applyStimulus(8'h75);
    checkKeys("up typematic", 5'b10000);
    applyStimulus(8'h75);
    checkKeys("bare 75 ignored", 5'b10000);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h75);
    checkKeys("up break", 5'b00000);

    applyStimulus(8'h29, 1'b1);
    checkOutput("scan_code held after parity error", {24'd0, scan_code}, 32'h75);
    checkKeys("keys after parity error", 5'b00000);

    // Latency: 2 synchronizer flops + edge register, then TIMEOUT cycles.
    pushErrors(1);
    sendPartial(frameBits(8'h6B, 1'b0), 0, 4);
    for (int n = 0; n < 4 * TIMEOUT && frame_err !== 1'b1; n++) @(negedge Clk);
    latency = cycleCount - lastFallCycle;
    checkOutput("timeout frame_err seen", {31'd0, frame_err}, 32'd1);
    checkOutput("timeout latency", latency, TIMEOUT + 3);
    checkOutput("fsm idle after timeout", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
    repeat (5) @(negedge Clk);
    applyStimulus(8'hE0);
    applyStimulus(8'h6B);
    checkKeys("left make after timeout", 5'b00100);

    applyStimulus(8'hE0);
    applyStimulus(8'h74);
    applyStimulus(8'h29);
    checkKeys("right and fire held", 5'b00111);

    applyStimulus(8'hE0);
    sendPartial(frameBits(8'hF0, 1'b0), 0, 4);
    repeat (2) @(negedge Clk);
    Reset_bar = 1'b0;
    @(negedge Clk);
    Reset_bar = 1'b1;
    checkOutput("mid-frame reset scan_code", {24'd0, scan_code}, 32'h00);
    checkOutput("mid-frame reset code_valid", {31'd0, code_valid}, 32'd0);
    checkOutput("mid-frame reset frame_err", {31'd0, frame_err}, 32'd0);
    checkKeys("mid-frame reset keys", 5'b00000);
    // Remaining F0 bits are all ones: each lands in IDLE as a bad start bit.
    pushErrors(6);
    sendPartial(frameBits(8'hF0, 1'b0), 5, 10);
    repeat (10) @(negedge Clk);
    applyStimulus(8'h74);
    checkKeys("keys after abandoned frame", 5'b00000);

    repeat (20) @(negedge Clk);
    checkOutput("scoreboard drained", expQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
